// File: rtl/router.sv
// Input-buffered credit-based NoC router with per-output round-robin allocation and a local eject sink.
// Latency: a flit loaded by LoadStaging can leave on the next Phase0; the staged output is registered.
// Backpressure: a network output sends only with credit > 0; full input FIFOs drop; pending injection waits for local FIFO space.
module router #(
    parameter int MAXIO         = 4,
    parameter int MAXIO_BIT     = 2,
    parameter int ROUTER_BIT    = 4,
    parameter int FLIT_SIZE     = 16,
    parameter int IN_CYCLE_SIZE = 16,
    parameter int DATA_SIZE     = 32,
    parameter int OP_SIZE       = 3,
    parameter int BUF_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [MAXIO*FLIT_SIZE-1:0]    out_staging,
    output logic [MAXIO*FLIT_SIZE-1:0]    out_cr_staging,
    output logic                          done,
    output logic                          can_inject,
    input  logic [OP_SIZE-1:0]            op,
    input  logic [MAXIO*FLIT_SIZE-1:0]    in_staging,
    input  logic [MAXIO*FLIT_SIZE-1:0]    in_cr_staging,
    input  logic [DATA_SIZE-1:0]          data,
    input  logic [IN_CYCLE_SIZE-1:0]      in_cycle
);
    // Input index MAXIO is the local injection FIFO; target index MAXIO is the eject sink.
    localparam int NIN = MAXIO + 1;
    localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int TW  = $clog2(NIN);
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
    localparam logic [TW-1:0] EJECT_C = TW'(MAXIO);

    localparam logic [OP_SIZE-1:0] OP_LOAD  = OP_SIZE'(1);
    localparam logic [OP_SIZE-1:0] OP_PH0   = OP_SIZE'(2);
    localparam logic [OP_SIZE-1:0] OP_PH1   = OP_SIZE'(3);
    localparam logic [OP_SIZE-1:0] OP_SETID = OP_SIZE'(4);
    localparam logic [OP_SIZE-1:0] OP_SETRT = OP_SIZE'(5);
    localparam logic [OP_SIZE-1:0] OP_INJ   = OP_SIZE'(6);

    logic [FLIT_SIZE-1:0]     mem_q   [NIN][BUF_DEPTH];
    logic [PW-1:0]            rd_q    [NIN];
    logic [PW-1:0]            wr_q    [NIN];
    logic [CW-1:0]            cnt_q   [NIN];
    logic [CW-1:0]            cred_q  [NIN];
    logic [TW-1:0]            lg_q    [NIN];
    logic [MAXIO_BIT-1:0]     route_q [2**ROUTER_BIT];
    logic [ROUTER_BIT-1:0]    id_q;
    logic                     pend_vld_q;
    logic [IN_CYCLE_SIZE-1:0] pend_cyc_q;
    logic [FLIT_SIZE-1:0]     pend_flit_q;
    logic [MAXIO*FLIT_SIZE-1:0] out_q;
    logic [MAXIO*FLIT_SIZE-1:0] out_cr_q;

    logic [FLIT_SIZE-1:0]     head     [NIN];
    logic [ROUTER_BIT-1:0]    dest     [NIN];
    logic [NIN-1:0]           req_vld;
    logic [TW-1:0]            req_tgt  [NIN];
    logic [NIN-1:0]           gnt_vld;
    logic [TW-1:0]            gnt_idx  [NIN];
    logic [NIN-1:0]           pop;
    logic [NIN-1:0]           push;
    logic [FLIT_SIZE-1:0]     push_dat [NIN];
    logic                     unused_cr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == BUF_DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // Head-of-line decode: every non-empty FIFO requests eject or its routed output.
    always_comb begin
        for (int i = 0; i < NIN; i++) begin
            head[i]    = mem_q[i][rd_q[i]];
            dest[i]    = head[i][FLIT_SIZE-2 -: ROUTER_BIT];
            req_vld[i] = 1'b0;
            req_tgt[i] = EJECT_C;
            if (cnt_q[i] != '0) begin
                if (dest[i] == id_q) begin
                    req_vld[i] = 1'b1;
                end else if (int'(route_q[dest[i]]) < MAXIO) begin
                    // Illegal table entries never request, so such flits stall in place.
                    req_vld[i] = 1'b1;
                    req_tgt[i] = TW'(route_q[dest[i]]);
                end
            end
        end
    end

    // Per-target round-robin: search begins one past the last winner; network outputs need credit.
    always_comb begin
        int idx;
        idx = 0;
        pop = '0;
        for (int o = 0; o < NIN; o++) begin
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = '0;
            for (int k = 1; k <= NIN; k++) begin
                idx = (int'(lg_q[o]) + k) % NIN;
                if (!gnt_vld[o] && req_vld[idx] && req_tgt[idx] == TW'(o) &&
                    (o == MAXIO || cred_q[o] != '0)) begin
                    gnt_vld[o] = 1'b1;
                    gnt_idx[o] = TW'(idx);
                end
            end
            if (gnt_vld[o]) pop[gnt_idx[o]] = 1'b1;
        end
    end

    // FIFO write requests: neighbour flits on LoadStaging, pending injection on Phase1.
    always_comb begin
        for (int p = 0; p < MAXIO; p++) begin
            push_dat[p] = in_staging[p*FLIT_SIZE +: FLIT_SIZE];
            push[p]     = (op == OP_LOAD) && in_staging[p*FLIT_SIZE + FLIT_SIZE - 1] &&
                          (cnt_q[p] != DEPTH_C);
        end
        push_dat[MAXIO] = pend_flit_q;
        push[MAXIO]     = (op == OP_PH1) && pend_vld_q && (in_cycle >= pend_cyc_q) &&
                          (cnt_q[MAXIO] != DEPTH_C);
    end

    // Flit storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NIN; i++) begin
            if (push[i]) mem_q[i][wr_q[i]] <= push_dat[i];
        end
    end

    // Control state: pointers, credits, grants, staging registers, configuration and pending injection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NIN; i++) begin
                rd_q[i]   <= '0;
                wr_q[i]   <= '0;
                cnt_q[i]  <= '0;
                cred_q[i] <= DEPTH_C;
                lg_q[i]   <= EJECT_C;
            end
            for (int r = 0; r < 2**ROUTER_BIT; r++) route_q[r] <= '0;
            id_q        <= '0;
            pend_vld_q  <= 1'b0;
            pend_cyc_q  <= '0;
            pend_flit_q <= '0;
            out_q       <= '0;
            out_cr_q    <= '0;
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (push[i]) begin
                    wr_q[i]  <= ptr_inc(wr_q[i]);
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
            case (op)
                OP_LOAD: begin
                    for (int p = 0; p < MAXIO; p++) begin
                        if (in_cr_staging[p*FLIT_SIZE] && cred_q[p] != DEPTH_C)
                            cred_q[p] <= cred_q[p] + CW'(1);
                    end
                end
                OP_PH0: begin
                    out_q    <= '0;
                    out_cr_q <= '0;
                    for (int i = 0; i < NIN; i++) begin
                        if (pop[i]) begin
                            rd_q[i]  <= ptr_inc(rd_q[i]);
                            cnt_q[i] <= cnt_q[i] - CW'(1);
                        end
                        if (gnt_vld[i]) lg_q[i] <= gnt_idx[i];
                    end
                    for (int o = 0; o < MAXIO; o++) begin
                        if (gnt_vld[o]) begin
                            out_q[o*FLIT_SIZE +: FLIT_SIZE] <= head[gnt_idx[o]];
                            cred_q[o] <= cred_q[o] - CW'(1);
                        end
                        if (pop[o]) out_cr_q[o*FLIT_SIZE +: FLIT_SIZE] <= FLIT_SIZE'(1);
                    end
                end
                OP_PH1: begin
                    if (push[MAXIO]) pend_vld_q <= 1'b0;
                end
                OP_SETID: id_q <= data[ROUTER_BIT-1:0];
                OP_SETRT: route_q[data[ROUTER_BIT+MAXIO_BIT-1:MAXIO_BIT]] <= data[MAXIO_BIT-1:0];
                OP_INJ: begin
                    if (!pend_vld_q) begin
                        pend_vld_q  <= 1'b1;
                        pend_cyc_q  <= data[DATA_SIZE-1:FLIT_SIZE];
                        pend_flit_q <= {1'b1, data[FLIT_SIZE-2:0]};
                    end
                end
                default: ;
            endcase
        end
    end

    // Idle status: all FIFOs drained and nothing waiting to be admitted.
    always_comb begin
        done = !pend_vld_q;
        for (int i = 0; i < NIN; i++) begin
            if (cnt_q[i] != '0) done = 1'b0;
        end
    end

    assign can_inject     = !pend_vld_q;
    assign out_staging    = out_q;
    assign out_cr_staging = out_cr_q;
    // Only bit 0 of each credit slice carries meaning.
    assign unused_cr      = ^in_cr_staging;
endmodule

// File: tb/tb_router.sv
// Directed bench for router: queue-based reference model checked every cycle, plus literal pins.
// Latency: model and DUT both advance on the rising edge; outputs compared on the falling edge.
// Backpressure: credit exhaustion, FIFO overflow drop and delayed injection are exercised explicitly.
module tb_router;
    localparam int F   = 16;
    localparam int N   = 4;
    localparam int NIN = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  op = '0;
    logic [63:0] in_staging = '0;
    logic [63:0] in_cr_staging = '0;
    logic [31:0] data = '0;
    logic [15:0] in_cycle = '0;
    logic [63:0] out_staging;
    logic [63:0] out_cr_staging;
    logic        done;
    logic        can_inject;

    router dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .out_staging    (out_staging),
        .out_cr_staging (out_cr_staging),
        .done           (done),
        .can_inject     (can_inject),
        .op             (op),
        .in_staging     (in_staging),
        .in_cr_staging  (in_cr_staging),
        .data           (data),
        .in_cycle       (in_cycle)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state
    logic [15:0] mq [NIN][$];
    int          m_cred [N];
    int          m_lg [NIN];
    logic [3:0]  m_id;
    logic [1:0]  m_rt [16];
    bit          m_pv;
    logic [15:0] m_pc;
    logic [15:0] m_pf;
    logic [63:0] m_out;
    logic [63:0] m_cr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NIN; i++) begin
            mq[i].delete();
            m_lg[i] = N;
        end
        for (int p = 0; p < N; p++) m_cred[p] = 4;
        for (int r = 0; r < 16; r++) m_rt[r] = 2'd0;
        m_id = 4'd0; m_pv = 1'b0; m_pc = '0; m_pf = '0; m_out = '0; m_cr = '0;
    endtask

    task automatic model_edge(input logic [2:0] o, input logic [31:0] d,
                              input logic [63:0] st, input logic [63:0] cr, input logic [15:0] cy);
        logic [15:0] f;
        logic [3:0]  dst;
        int          tgt [NIN];
        bit          has [NIN];
        int          i;
        case (o)
            3'd1: begin
                for (int p = 0; p < N; p++) begin
                    f = st[p*F +: F];
                    if (f[15] && mq[p].size() < 4) mq[p].push_back(f);
                    if (cr[p*F] && m_cred[p] < 4) m_cred[p]++;
                end
            end
            3'd2: begin
                m_out = '0;
                m_cr  = '0;
                for (int k = 0; k < NIN; k++) begin
                    has[k] = mq[k].size() != 0;
                    tgt[k] = N;
                    if (has[k]) begin
                        f = mq[k][0];
                        dst = f[14:11];
                        tgt[k] = (dst == m_id) ? N : int'(m_rt[dst]);
                    end
                end
                for (int t = 0; t < NIN; t++) begin
                    for (int k = 1; k <= NIN; k++) begin
                        i = (m_lg[t] + k) % NIN;
                        if (has[i] && tgt[i] == t && (t == N || m_cred[t] > 0)) begin
                            f = mq[i].pop_front();
                            if (t < N) begin
                                m_out[t*F +: F] = f;
                                m_cred[t]--;
                            end
                            if (i < N) m_cr[i*F] = 1'b1;
                            m_lg[t] = i;
                            break;
                        end
                    end
                end
            end
            3'd3: begin
                if (m_pv && cy >= m_pc && mq[N].size() < 4) begin
                    mq[N].push_back(m_pf);
                    m_pv = 1'b0;
                end
            end
            3'd4: m_id = d[3:0];
            3'd5: m_rt[d[5:2]] = d[1:0];
            3'd6: begin
                if (!m_pv) begin
                    m_pv = 1'b1;
                    m_pc = d[31:16];
                    m_pf = d[15:0] | 16'h8000;
                end
            end
            default: ;
        endcase
    endtask

    // Drive one op, advance model with the DUT, return on the following falling edge.
    task automatic step(input logic [2:0] o, input logic [31:0] d = '0,
                        input logic [63:0] st = '0, input logic [63:0] cr = '0,
                        input logic [15:0] cy = '0);
        op = o; data = d; in_staging = st; in_cr_staging = cr; in_cycle = cy;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge(o, d, st, cr, cy);
        @(negedge clk);
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        bit mdone;
        if (chk_en) begin
            mdone = !m_pv;
            for (int k = 0; k < NIN; k++) if (mq[k].size() != 0) mdone = 1'b0;
            check("out_staging", out_staging, m_out);
            check("out_cr_staging", out_cr_staging, m_cr);
            check("done", 64'(done), 64'(mdone));
            check("can_inject", 64'(can_inject), 64'(!m_pv));
        end
    end

    initial begin
        // Reset and idle
        rst_n = 1'b0;
        step(3'd0);
        step(3'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        repeat (3) step(3'd0);
        check("lit_reset_done", 64'(done), 64'd1);
        check("lit_reset_caninj", 64'(can_inject), 64'd1);
        check("lit_reset_out", out_staging, 64'd0);
        check("lit_reset_cr", out_cr_staging, 64'd0);

        // Id 3, dest 5 -> port 2, inject and forward
        step(3'd4, 32'd3);
        step(3'd5, 32'h16);
        step(3'd6, {16'd0, 16'hA82A});
        check("lit_inj_caninj", 64'(can_inject), 64'd0);
        step(3'd3, '0, '0, '0, 16'd0);
        check("lit_ph1_done", 64'(done), 64'd0);
        step(3'd2);
        check("lit_fwd_slice2", 64'(out_staging[47:32]), 64'hA82A);
        check("lit_fwd_model", m_out, 64'h0000_A82A_0000_0000);
        check("lit_fwd_done", 64'(done), 64'd1);
        check("lit_fwd_nocr", out_cr_staging, 64'd0);

        // Delayed injection
        step(3'd6, {16'd10, 16'hA82B});
        step(3'd3, '0, '0, '0, 16'd9);
        check("lit_early_caninj", 64'(can_inject), 64'd0);
        step(3'd3, '0, '0, '0, 16'd10);
        check("lit_ontime_caninj", 64'(can_inject), 64'd1);
        step(3'd2);
        check("lit_delay_slice2", 64'(out_staging[47:32]), 64'hA82B);

        // Eject via port 1
        step(3'd1, '0, {32'd0, 16'h9811, 16'd0});
        check("lit_load_hold", out_staging, 64'h0000_A82B_0000_0000);
        step(3'd2);
        check("lit_eject_cr", out_cr_staging, 64'h0000_0000_0001_0000);
        check("lit_eject_out", out_staging, 64'd0);
        check("lit_eject_done", 64'(done), 64'd1);

        // Restore port-2 credits (third return saturates), then exhaust them
        repeat (3) step(3'd1, '0, '0, 64'h0000_0001_0000_0000);
        step(3'd1, '0, 64'h0000_0000_A802_A801);
        step(3'd1, '0, 64'h0000_0000_A804_A803);
        step(3'd1, '0, 64'h0000_0000_0000_A805);
        step(3'd2);
        check("lit_rr0", out_staging, 64'h0000_A801_0000_0000);
        check("lit_rr0_cr", out_cr_staging, 64'h0000_0000_0000_0001);
        step(3'd2);
        check("lit_rr1", out_staging, 64'h0000_A802_0000_0000);
        check("lit_rr1_cr", out_cr_staging, 64'h0000_0000_0001_0000);
        step(3'd2);
        check("lit_rr2_cr", out_cr_staging, 64'h0000_0000_0000_0001);
        step(3'd2);
        check("lit_rr3", out_staging, 64'h0000_A804_0000_0000);
        check("lit_rr3_cr", out_cr_staging, 64'h0000_0000_0001_0000);
        step(3'd2);
        check("lit_stall_out", out_staging, 64'd0);
        check("lit_stall_done", 64'(done), 64'd0);
        step(3'd1, '0, '0, 64'h0000_0001_0000_0000);
        step(3'd2);
        check("lit_resume", 64'(out_staging[47:32]), 64'hA805);
        check("lit_resume_done", 64'(done), 64'd1);

        // FIFO overflow on port 3: fifth flit dropped
        step(3'd5, 32'h1D);
        for (int n = 1; n <= 5; n++) step(3'd1, '0, {16'hB810 + 16'(n), 48'd0});
        for (int n = 1; n <= 4; n++) begin
            step(3'd2);
            check("lit_drop_fwd", 64'(out_staging[31:16]), 64'(16'hB810 + 16'(n)));
            check("lit_drop_cr", 64'(out_cr_staging[63:48]), 64'd1);
        end
        check("lit_drop_done", 64'(done), 64'd1);
        step(3'd2);
        check("lit_drop_empty", out_staging, 64'd0);

        // Second inject while pending is ignored
        step(3'd6, {16'd0, 16'hA8F1});
        step(3'd6, {16'd0, 16'hA8F2});
        step(3'd3);
        step(3'd1, '0, '0, 64'h0000_0001_0000_0000);
        step(3'd2);
        check("lit_first_inj", 64'(out_staging[47:32]), 64'hA8F1);
        step(3'd7);
        check("lit_nop7_done", 64'(done), 64'd1);

        // Reset wins over a same-edge inject
        step(3'd6, {16'd0, 16'hA8F3});
        rst_n = 1'b0;
        step(3'd6, {16'd0, 16'hA8F4});
        rst_n = 1'b1;
        step(3'd0);
        check("lit_rstprio_caninj", 64'(can_inject), 64'd1);
        check("lit_rstprio_out", out_staging, 64'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
